// File: rtl/wbus_arbiter.sv
// Round-robin W-bus arbiter: grants one register-to-register transfer at a time and
// sequences it through DRIVE -> LOAD -> TURN so the bus always gets a dead cycle.
module wbus_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NSRC = 8,
  parameter int unsigned NDST = 8,
  parameter int unsigned SRCW = 3
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic [NREQ-1:0]        iReq,
  input  logic [NREQ*SRCW-1:0]   iSrc,
  input  logic [NREQ*NDST-1:0]   iDst,
  output logic [NREQ-1:0]        oGnt,
  output logic [NREQ-1:0]        oDone,
  output logic [NSRC-1:0]        oEn,
  output logic [NDST-1:0]        oLoad,
  output logic                   oBusy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StLoad  = 2'd2,
    StTurn  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [SRCW-1:0] src_q, src_d;
  logic [NDST-1:0] dst_q, dst_d;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NDST-1:0] load_q, load_d;
  logic            busy_q, busy_d;

  logic            found;
  logic [PW-1:0]   win;

  // Out-of-range source indices leave every driver off rather than aliasing.
  function automatic logic [NSRC-1:0] src_dec(input logic [SRCW-1:0] s);
    logic [NSRC-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (32'(s) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Rotating priority scan starting at ptr_q, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned k;
      k = 32'(ptr_q) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && iReq[PW'(k)]) begin
        found = 1'b1;
        win   = PW'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    src_d   = src_q;
    dst_d   = dst_q;
    gnt_d   = '0;
    done_d  = '0;
    en_d    = '0;
    load_d  = '0;

    unique case (state_q)
      StIdle, StTurn: begin
        if (found) begin
          state_d    = StDrive;
          win_d      = win;
          src_d      = iSrc[32'(win)*SRCW +: SRCW];
          dst_d      = iDst[32'(win)*NDST +: NDST];
          ptr_d      = (32'(win) == NREQ - 1) ? '0 : win + PW'(1);
          gnt_d[win] = 1'b1;
          en_d       = src_dec(src_d);
        end else begin
          state_d = StIdle;
        end
      end
      StDrive: begin
        state_d = StLoad;
        en_d    = src_dec(src_q);
        load_d  = dst_q;
      end
      StLoad: begin
        state_d       = StTurn;
        done_d[win_q] = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      en_q    <= '0;
      load_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      en_q    <= en_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
    end
  end

  assign oGnt  = gnt_q;
  assign oDone = done_q;
  assign oEn   = en_q;
  assign oLoad = load_q;
  assign oBusy = busy_q;

  // Bus-safety invariants; outputs are registered so they track state_q directly.
  a_en_onehot0:   assert property (@(posedge iClk) $onehot0(oEn));
  a_gnt_onehot0:  assert property (@(posedge iClk) $onehot0(oGnt));
  a_done_onehot0: assert property (@(posedge iClk) $onehot0(oDone));
  a_load_in_load: assert property (@(posedge iClk) (oLoad != '0) |-> (state_q == StLoad));
  a_busy_state:   assert property (@(posedge iClk) oBusy == (state_q != StIdle));

endmodule

// File: tb/tb_wbus_arbiter.sv
// Directed bench for wbus_arbiter: transfer timing, round-robin order, reset abort,
// operand capture, and continuous bus-safety checks.
module tb_wbus_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned NSRC = 8;
  localparam int unsigned NDST = 8;
  localparam int unsigned SRCW = 3;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*SRCW-1:0] src_bus;
  logic [NREQ*NDST-1:0] dst_bus;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [NSRC-1:0]      en;
  logic [NDST-1:0]      load;
  logic                 busy;

  int vectors;
  int errors;

  wbus_arbiter #(
    .NREQ(NREQ),
    .NSRC(NSRC),
    .NDST(NDST),
    .SRCW(SRCW)
  ) dut (
    .iClk  (clk),
    .iRst_n(rst_n),
    .iReq  (req),
    .iSrc  (src_bus),
    .iDst  (dst_bus),
    .oGnt  (gnt),
    .oDone (done),
    .oEn   (en),
    .oLoad (load),
    .oBusy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [SRCW-1:0] s, input logic [NDST-1:0] d);
    src_bus[k*SRCW +: SRCW] = s;
    dst_bus[k*NDST +: NDST] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  32'(gnt),  32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_en"},   32'(en),   32'h0);
    chk({tag, "_load"}, 32'(load), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Bus safety is checked every cycle, away from the active edge.
  always @(negedge clk) begin
    vectors++;
    assert ($countones(en) <= 1) else begin
      errors++;
      $error("FAIL en_onehot0: observed %0h expected at most one bit", en);
    end
    vectors++;
    assert (load == '0 || en != '0) else begin
      errors++;
      $error("FAIL load_without_en: observed load %0h en %0h expected load 0", load, en);
    end
  end

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    req     = '0;
    src_bus = '0;
    dst_bus = '0;

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // Single transfer: C -> reg0
    req = 4'b0001;
    set_op(0, 3'd2, 8'h01);
    tick();
    chk("single_gnt",  32'(gnt),  32'h1);
    chk("single_en0",  32'(en),   32'h04);
    chk("single_ld0",  32'(load), 32'h00);
    chk("single_busy", 32'(busy), 32'h1);
    req = '0;
    tick();
    chk("single_gnt1", 32'(gnt),  32'h0);
    chk("single_ld1",  32'(load), 32'h01);
    chk("single_en1",  32'(en),   32'h04);
    tick();
    chk("single_done", 32'(done), 32'h1);
    chk("single_en2",  32'(en),   32'h00);
    chk("single_ld2",  32'(load), 32'h00);
    tick();
    chk("single_idle", 32'(busy), 32'h0);
    chk("single_done3", 32'(done), 32'h0);

    // All four held from reset: grants 0,1,2,3,0 back to back
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) set_op(k, SRCW'(k), NDST'(1 << k));
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int k;
      k = g % 4;
      tick();
      chk($sformatf("rr_gnt%0d", g),  32'(gnt),  32'(1 << k));
      chk($sformatf("rr_en%0d", g),   32'(en),   32'(1 << k));
      tick();
      chk($sformatf("rr_load%0d", g), 32'(load), 32'(1 << k));
      if (g == 4) req = '0;
      tick();
      chk($sformatf("rr_dead%0d", g), 32'(en),   32'h0);
      chk($sformatf("rr_done%0d", g), 32'(done), 32'(1 << k));
    end
    tick();
    chk("rr_idle", 32'(busy), 32'h0);

    // Pointer wrap: grant 2 alone, then 0 and 2 together -> 0 first
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_op(0, 3'd1, 8'h02);
    set_op(2, 3'd5, 8'h10);
    req = 4'b0100;
    tick();
    chk("wrap_gnt2a", 32'(gnt), 32'h4);
    req = '0;
    tick();
    req = 4'b0101;
    tick();
    chk("wrap_done2a", 32'(done), 32'h4);
    tick();
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    chk("wrap_en0",  32'(en),  32'h02);
    req = 4'b0100;
    tick();
    chk("wrap_ld0", 32'(load), 32'h02);
    tick();
    chk("wrap_done0", 32'(done), 32'h1);
    tick();
    chk("wrap_gnt2b", 32'(gnt), 32'h4);
    chk("wrap_en2b",  32'(en),  32'h20);
    req = '0;
    tick();
    chk("wrap_ld2b", 32'(load), 32'h10);
    tick();
    tick();
    chk("wrap_idle", 32'(busy), 32'h0);

    // Reset during LOAD aborts the transfer and clears ptr
    set_op(1, 3'd4, 8'h08);
    set_op(3, 3'd6, 8'h40);
    req = 4'b0010;
    tick();
    chk("abort_gnt", 32'(gnt), 32'h2);
    req = '0;
    tick();
    chk("abort_inload", 32'(load), 32'h08);
    rst_n = 1'b0;
    tick();
    chk_all_zero("abort");
    rst_n = 1'b1;
    tick();
    chk("abort_nodone", 32'(done), 32'h0);
    req = 4'b1010;
    tick();
    chk("abort_ptr0_gnt", 32'(gnt), 32'h2);
    chk("abort_ptr0_en",  32'(en),  32'h10);
    req = '0;
    tick();
    tick();
    tick();
    chk("abort_idle", 32'(busy), 32'h0);

    // Operand capture and self-load of source 7
    set_op(3, 3'd7, 8'h80);
    req = 4'b1000;
    tick();
    chk("stab_gnt", 32'(gnt), 32'h8);
    chk("stab_en0", 32'(en),  32'h80);
    req = '0;
    set_op(3, 3'd0, 8'h01);
    tick();
    chk("stab_ld", 32'(load), 32'h80);
    chk("stab_en1", 32'(en),  32'h80);
    tick();
    chk("stab_done", 32'(done), 32'h8);
    chk("stab_en2",  32'(en),   32'h0);
    tick();
    chk("stab_idle", 32'(busy), 32'h0);

    // Empty destination mask still sequences
    set_op(0, 3'd3, 8'h00);
    req = 4'b0001;
    tick();
    chk("nodst_gnt", 32'(gnt), 32'h1);
    chk("nodst_en",  32'(en),  32'h08);
    req = '0;
    tick();
    chk("nodst_ld", 32'(load), 32'h00);
    tick();
    chk("nodst_done", 32'(done), 32'h1);
    tick();
    chk("nodst_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
